// File: rtl/pes_usr_rx.sv
// pes_usr_rx: serial-in/parallel-out receiver with a one-entry valid/ready output.
// Optional even-parity bit per word when PES_USR_RX_PARITY_EN is defined.
module pes_usr_rx #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             dir,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  input  logic             q_ready,
  output logic             ovf,
  output logic             par_err
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    S_DATA,
    S_PAR
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d, sh;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dir_q, dir_d, dir_e;
  logic [WIDTH-1:0] q_q, q_d, word;
  logic             qv_q, qv_d;
  logic             ovf_q, ovf_d;
  logic             done;
`ifdef PES_USR_RX_PARITY_EN
  logic             perr_q, perr_d, perr_new;
`endif

  // dir is sampled live on the first bit, then held for the rest of the word
  assign dir_e = (cnt_q == '0) ? dir : dir_q;
  assign sh    = dir_e ? {sr_q[WIDTH-2:0], sin}
                       : {sin, sr_q[WIDTH-1:1]};

  // next-state: bit assembly, word completion and output register update
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    done    = 1'b0;
    word    = sh;
    q_d     = q_q;
    qv_d    = qv_q;
    ovf_d   = ovf_q;
`ifdef PES_USR_RX_PARITY_EN
    perr_d   = perr_q;
    perr_new = 1'b0;
`endif
    if (clr) begin
      sr_d    = '0;
      cnt_d   = '0;
      state_d = S_DATA;
      ovf_d   = 1'b0;
    end else if (sin_valid) begin
      if (state_q == S_PAR) begin
        done    = 1'b1;
        word    = sr_q;
        state_d = S_DATA;
`ifdef PES_USR_RX_PARITY_EN
        perr_new = (^sr_q) ^ sin;
`endif
      end else begin
        sr_d = sh;
        if (cnt_q == '0) dir_d = dir;
        if (cnt_q == CW'(WIDTH - 1)) begin
          cnt_d = '0;
`ifdef PES_USR_RX_PARITY_EN
          state_d = S_PAR;
`else
          done = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
    if (done) begin
      if (qv_q && !q_ready) begin
        ovf_d = 1'b1;
      end else begin
        q_d  = word;
        qv_d = 1'b1;
`ifdef PES_USR_RX_PARITY_EN
        perr_d = perr_new;
`endif
      end
    end else if (qv_q && q_ready) begin
      qv_d = 1'b0;
    end
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_DATA;
      sr_q    <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      q_q     <= '0;
      qv_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      q_q     <= q_d;
      qv_q    <= qv_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef PES_USR_RX_PARITY_EN
  // parity error tag lives with the word in q
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perr_q <= 1'b0;
    else        perr_q <= perr_d;
  end

  assign par_err = perr_q;
`else
  assign par_err = 1'b0;
`endif

  assign q       = q_q;
  assign q_valid = qv_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_pes_usr_rx.sv
// tb_pes_usr_rx: directed cases plus random traffic against a word-level model.
// Build with PES_USR_RX_PARITY_EN to exercise the parity variant.
module tb_pes_usr_rx;

  localparam int W = 4;
`ifdef PES_USR_RX_PARITY_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clr = 1'b0;
  logic         sin = 1'b0;
  logic         sin_valid = 1'b0;
  logic         dir = 1'b0;
  logic         q_ready = 1'b0;
  logic [W-1:0] q;
  logic         q_valid;
  logic         ovf;
  logic         par_err;

  pes_usr_rx #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .sin       (sin),
    .sin_valid (sin_valid),
    .dir       (dir),
    .q         (q),
    .q_valid   (q_valid),
    .q_ready   (q_ready),
    .ovf       (ovf),
    .par_err   (par_err)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  int mq;
  bit mqv, movf, mperr, mdir, minpar;
  bit bits[$];

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    nvec++;
    if (o !== e) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", tag, o, e);
    end
  endtask

  task automatic cmp_all();
    chk("q", 32'(q), 32'(mq));
    chk("q_valid", 32'(q_valid), 32'(mqv));
    chk("ovf", 32'(ovf), 32'(movf));
    chk("par_err", 32'(par_err), 32'(mperr));
  endtask

  task automatic model_reset();
    mq = 0; mqv = 0; movf = 0; mperr = 0;
    mdir = 0; minpar = 0;
    bits.delete();
  endtask

  // word-level model: collect bits, build the word arithmetically on completion
  task automatic model_edge();
    bit done, pb, par;
    int w;
    done = 0; pb = 0;
    if (clr) begin
      bits.delete();
      minpar = 0;
      movf = 0;
    end else if (sin_valid) begin
      if (minpar) begin
        done = 1; pb = sin; minpar = 0;
      end else begin
        if (bits.size() == 0) mdir = dir;
        bits.push_back(sin);
        if (bits.size() == W) begin
          if (PEN) minpar = 1;
          else done = 1;
        end
      end
    end
    if (done) begin
      w = 0; par = 0;
      for (int i = 0; i < W; i++) begin
        if (bits[i]) w += mdir ? (1 << (W - 1 - i)) : (1 << i);
        par ^= bits[i];
      end
      bits.delete();
      if (mqv && !q_ready) movf = 1;
      else begin
        mq = w; mqv = 1;
        mperr = PEN ? (par ^ pb) : 1'b0;
      end
    end else if (mqv && q_ready) begin
      mqv = 0;
    end
  endtask

  task automatic cyc(input bit c, input bit v, input bit s,
                     input bit d, input bit r);
    @(negedge clk);
    cmp_all();
    clr = c; sin_valid = v; sin = s; dir = d; q_ready = r;
    model_edge();
  endtask

  // b[0] arrives first; rl is q_ready on the completing edge
  task automatic send(input logic [W-1:0] b, input bit d, input bit tog,
                      input bit r, input bit rl, input bit badpar,
                      input bit gap);
    bit dd, last;
    for (int i = 0; i < W; i++) begin
      if (gap) cyc(0, 0, 0, ~d, r);
      dd = (tog && i >= 2) ? ~d : d;
      last = (i == W - 1) && !PEN;
      cyc(0, 1, b[i], dd, last ? rl : r);
    end
    if (PEN) begin
      if (gap) cyc(0, 0, 0, d, r);
      cyc(0, 1, (^b) ^ badpar, d, rl);
    end
  endtask

  initial begin
    model_reset();
    #12;
    chk("rst_q", 32'(q), 0);
    chk("rst_valid", 32'(q_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // LSB-first 1,0,1,1
    send(4'b1101, 0, 0, 1, 1, 0, 0);
    cyc(0, 0, 0, 0, 1);
    chk("t1_q", 32'(q), 32'hD);
    chk("t1_valid", 32'(q_valid), 1);
    cyc(0, 0, 0, 0, 1);
    chk("t1_drop", 32'(q_valid), 0);

    // MSB-first, then with dir toggled mid-word
    send(4'b1101, 1, 0, 1, 1, 0, 0);
    cyc(0, 0, 0, 0, 1);
    chk("t2_q", 32'(q), 32'hB);
    send(4'b1101, 1, 1, 1, 1, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("t2_tog", 32'(q), 32'hB);

    // overflow then clr
    send(4'hA, 0, 0, 0, 0, 0, 0);
    send(4'h5, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("t3_q", 32'(q), 32'hA);
    chk("t3_ovf", 32'(ovf), 1);
    cyc(1, 1, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("t3_clr_ovf", 32'(ovf), 0);
    chk("t3_clr_q", 32'(q), 32'hA);
    chk("t3_clr_v", 32'(q_valid), 1);

    // completion coincides with consume
    send(4'h3, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("t4_q", 32'(q), 32'h3);
    chk("t4_valid", 32'(q_valid), 1);
    chk("t4_ovf", 32'(ovf), 0);
    cyc(0, 0, 0, 0, 1);

    // reset mid-word
    cyc(0, 1, 1, 0, 1);
    cyc(0, 1, 1, 0, 1);
    @(negedge clk);
    cmp_all();
    sin_valid = 0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("t5_q", 32'(q), 0);
    chk("t5_valid", 32'(q_valid), 0);
    chk("t5_ovf", 32'(ovf), 0);
    chk("t5_perr", 32'(par_err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    send(4'h6, 0, 0, 1, 1, 0, 0);
    cyc(0, 0, 0, 0, 1);
    chk("t5_word", 32'(q), 32'h6);

`ifdef PES_USR_RX_PARITY_EN
    send(4'b0011, 0, 0, 1, 1, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("t6_ok", 32'(par_err), 0);
    chk("t6_q", 32'(q), 32'h3);
    send(4'b0011, 0, 0, 1, 1, 1, 1);
    cyc(0, 0, 0, 0, 1);
    chk("t6_err", 32'(par_err), 1);
    chk("t6_q2", 32'(q), 32'h3);
`endif

    for (int n = 0; n < 3000; n++) begin
      cyc($urandom_range(0, 19) == 0, $urandom_range(0, 9) < 6,
          1'($urandom), 1'($urandom), 1'($urandom));
    end
    @(negedge clk);
    cmp_all();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
